sha256_core_arbiter: RTL
========================

SHA256_CORE_ARBITER -- requirements
Module: sha256_core_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one SHA256 compression core (2..8).
REQ-002 Parameter TIMEOUT, default 200: maximum cycles in RUN before the job is aborted (must exceed 66).
REQ-003 clock  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  NUM_REQ  per-requester job request; held until accepted.
REQ-006 req_block  input  512*NUM_REQ  flattened padded 512-bit blocks; requester i occupies bits [512*i+511 : 512*i].
REQ-007 req_ready  output  NUM_REQ  one-hot accept strobe.
REQ-008 resp_valid  output  NUM_REQ  one-hot response-valid, held until that requester's resp_ready.
REQ-009 resp_ready  input  NUM_REQ  per-requester response accept.
REQ-010 resp_hash  output  256  digest of the granted job, big-endian, H0 in [255:224].
REQ-011 resp_error  output  1  qualifies resp_valid: job timed out; resp_hash is zero.
REQ-012 core_clear  output  1  one-cycle pulse resetting the core before each job.
REQ-013 core_start  output  1  level start to the core; high for the whole of RUN.
REQ-014 core_block  output  512  registered block of the granted job.
REQ-015 core_done  input  1  sticky done from the core.
REQ-016 core_hash  input  256  final hash from the core, valid while core_done is high.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 grant_id  output  3  index of the current or last granted requester.

Function
REQ-019 States SHALL be IDLE, CLEAR, RUN and RESP, encoded in a 2-bit register.
REQ-020 IDLE: if any req_valid is high, the arbiter SHALL select one requester by round-robin, searching from last_grant+1 modulo NUM_REQ.
REQ-021 In IDLE with a selection, req_ready[g] SHALL be 1 for that same cycle only; req_block[g] is captured into core_block, grant_id becomes g, and the next state is CLEAR.
REQ-022 req_ready SHALL be all-zero in every state other than IDLE, and in IDLE when no req_valid is high.
REQ-023 CLEAR: core_clear SHALL be 1 for exactly one cycle, the cycle counter cleared, next state RUN.
REQ-024 RUN: core_start SHALL be 1 and the counter SHALL increment each cycle.
REQ-025 In RUN, when core_done is 1, core_hash SHALL be registered into resp_hash, resp_error set to 0, next state RESP.
REQ-026 In RUN, when the counter reaches TIMEOUT-1 without core_done, resp_hash SHALL be set to 0, resp_error to 1, next state RESP.
REQ-027 If core_done and timeout occur in the same cycle, core_done SHALL win.
REQ-028 RESP: resp_valid[g] SHALL be held high with resp_hash and resp_error stable.
REQ-029 The RESP handshake completes only when resp_ready[g] is 1 in a RESP cycle.
REQ-030 On handshake, last_grant SHALL become g, resp_valid SHALL drop on the next cycle, and the next state SHALL be IDLE.
REQ-031 resp_ready on non-granted lines, or outside RESP, SHALL be ignored.
REQ-032 Latency: accept at cycle T gives core_clear at T+1 and core_start from T+2; resp_valid SHALL rise one cycle after core_done is first sampled high.
REQ-033 A new grant SHALL not be issued in the same cycle as a response handshake; the earliest next accept is the cycle after returning to IDLE.
REQ-034 Fairness: with all requesters continuously valid, grants SHALL rotate 0,1,2,...,NUM_REQ-1,0,...
REQ-035 The round-robin pointer SHALL wrap from NUM_REQ-1 to 0.
REQ-036 Requests deasserted before acceptance SHALL simply not be granted; no state change results.

Reset
REQ-037 On reset assertion, all outputs SHALL go to 0 asynchronously, state to IDLE, counter to 0 and last_grant to NUM_REQ-1, so requester 0 has first priority.
REQ-038 Reset during CLEAR, RUN or RESP SHALL drop the in-flight job with no response, and core_start SHALL fall immediately.
REQ-039 After reset deasserts, the first clock edge SHALL be able to accept a request.

Verification
REQ-040 Single job: req_valid=4'b0001 with the padded "abc" block at T -> req_ready[0]=1 at T, core_clear at T+1, resp_valid[0]=1 with resp_hash=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, resp_error=0.
REQ-041 Contention: req_valid=4'b1111 held throughout -> grant order 0,1,2,3,0, and exactly one resp_valid bit is high at any time.
REQ-042 Timeout: core model never asserts done, TIMEOUT=80 -> resp_valid[g]=1, resp_error=1, resp_hash=0 exactly 80 RUN cycles after core_start rose.
REQ-043 Backpressure: resp_ready held low for 10 cycles in RESP -> resp_valid and resp_hash stable for those 10 cycles, and no req_ready is issued.
REQ-044 Mid-run reset: reset pulsed 30 cycles into RUN -> all outputs 0 at once, busy=0, and the next request from requester 0 is granted first.
REQ-045 Simultaneous event: core_done rises in the same cycle the counter hits TIMEOUT-1 -> resp_error=0 and resp_hash=core_hash.

Source files
------------

// File: rtl/sha256_core_arbiter_if.sv
// Requester-side bus of the SHA256 core arbiter: job requests in, digests out.
// The arbiter takes the slave modport; the requester pool drives the master side.
interface sha256_core_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]     req_valid;
  logic [512*NUM_REQ-1:0] req_block;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ-1:0]     resp_valid;
  logic [NUM_REQ-1:0]     resp_ready;
  logic [255:0]           resp_hash;
  logic                   resp_error;

  modport master (
    output req_valid, req_block, resp_ready,
    input  req_ready, resp_valid, resp_hash, resp_error
  );

  modport slave (
    input  req_valid, req_block, resp_ready,
    output req_ready, resp_valid, resp_hash, resp_error
  );
endinterface

// File: rtl/sha256_core_arbiter.sv
// Round-robin arbiter sharing one SHA256 compression core between NUM_REQ
// requesters: grant, clear core, run with timeout watchdog, hold response.
module sha256_core_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 200
) (
  input  logic                  clock,
  input  logic                  reset,
  sha256_core_arbiter_if.slave  bus,
  output logic                  core_clear,
  output logic                  core_start,
  output logic [511:0]          core_block,
  input  logic                  core_done,
  input  logic [255:0]          core_hash,
  output logic                  busy,
  output logic [2:0]            grant_id
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, RESP} state_t;

  state_t               state;
  logic [CW-1:0]        counter;
  logic [IW-1:0]        last_grant;
  logic [IW-1:0]        grant_q;
  logic                 sel_valid;
  logic [IW-1:0]        sel_idx;
  logic [IW-1:0]        probe;

  // Round-robin search from last_grant+1; scanning the farthest offset first
  // lets the nearest valid requester overwrite the selection last.
  // NOTE: every variable assigned here gets a default first, otherwise the
  // conditional assignments below would infer latches.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    probe     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      probe = IW'((int'(last_grant) + k) % NUM_REQ);
      if (bus.req_valid[probe]) begin
        sel_valid = 1'b1;
        sel_idx   = probe;
      end
    end
  end

  // The accept strobe must be visible in the selecting cycle itself, so it is
  // the one combinational output; reset gates it to keep all outputs at zero.
  assign bus.req_ready = (state == IDLE && sel_valid && !reset)
                         ? (NUM_REQ'(1) << sel_idx) : '0;

  assign busy     = (state != IDLE);
  assign grant_id = 3'(grant_q);

  // NOTE: state and registered outputs use non-blocking assignments so every
  // flop samples pre-edge values; the reset branch is asynchronous.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      counter        <= '0;
      last_grant     <= IW'(NUM_REQ - 1);
      grant_q        <= '0;
      core_block     <= '0;
      core_clear     <= 1'b0;
      core_start     <= 1'b0;
      bus.resp_valid <= '0;
      bus.resp_hash  <= '0;
      bus.resp_error <= 1'b0;
    end else begin
      core_clear <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_valid) begin
            grant_q    <= sel_idx;
            core_block <= bus.req_block[512*sel_idx +: 512];
            core_clear <= 1'b1;
            state      <= CLEAR;
          end
        end
        CLEAR: begin
          counter    <= '0;
          core_start <= 1'b1;
          state      <= RUN;
        end
        RUN: begin
          counter <= counter + 1'b1;
          // core_done is checked first so it wins a tie with the watchdog
          if (core_done) begin
            bus.resp_hash  <= core_hash;
            bus.resp_error <= 1'b0;
            bus.resp_valid <= NUM_REQ'(1) << grant_q;
            core_start     <= 1'b0;
            state          <= RESP;
          end else if (counter == CW'(TIMEOUT - 1)) begin
            bus.resp_hash  <= '0;
            bus.resp_error <= 1'b1;
            bus.resp_valid <= NUM_REQ'(1) << grant_q;
            core_start     <= 1'b0;
            state          <= RESP;
          end
        end
        RESP: begin
          if (bus.resp_ready[grant_q]) begin
            last_grant     <= grant_q;
            bus.resp_valid <= '0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
